exc_sequencer: RTL and testbench
================================

EXC_SEQUENCER -- requirements
Module: exc_sequencer

Interface
REQ-001 Parameter VECTOR_ADDR, default 16'h0FF0: handler entry PC.
REQ-002 Parameter FLUSH_CYCLES, default 2: pipeline flush length in cycles, legal range 1..15.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: rst  in  1  async active-high reset.
REQ-006 Port: instruct  in  16  current decode-stage instruction; opcode = instruct[15:12].
REQ-007 Port: instr_valid  in  1  instruct holds a real instruction this cycle.
REQ-008 Port: overflow  in  1  ALU overflow for the instruction in instruct.
REQ-009 Port: pc_in  in  16  PC of the instruction in instruct.
REQ-010 Port: eret  in  1  return-from-exception decoded, one-cycle pulse.
REQ-011 Port: flush  out  1  squash pipeline registers.
REQ-012 Port: stall  out  1  hold the PC and fetch.
REQ-013 Port: pc_sel  out  1  PC mux takes pc_target instead of PC+1.
REQ-014 Port: pc_target  out  16  redirect address.
REQ-015 Port: epc  out  16  saved PC of the faulting instruction.
REQ-016 Port: cause  out  2  00 none, 01 overflow, 10 illegal opcode.
REQ-017 Port: in_handler  out  1  handler code is executing.
REQ-018 Port: fatal  out  1  nested exception; machine locked.
REQ-019 Port: exc_count  out  8  exceptions taken, saturating.

Function
REQ-020 Legal opcodes SHALL be {0,4,5,6,8,B,C,F}; any other opcode with instr_valid=1 SHALL be an illegal-opcode event.
REQ-021 An overflow event SHALL be overflow=1 with instr_valid=1.
REQ-022 If both events occur together, overflow SHALL take priority (cause=01).
REQ-023 The FSM states SHALL be IDLE, FLUSH, VECTOR, HANDLER, RETURN, FATAL.
REQ-024 IDLE: on a clock edge with an event, the block SHALL load epc<=pc_in and cause<=code, increment exc_count (saturating at 255), and go to FLUSH.
REQ-025 FLUSH: flush=1 and stall=1 SHALL hold for exactly FLUSH_CYCLES cycles, counted by a down-counter, then go to VECTOR.
REQ-026 VECTOR: the block SHALL assert pc_sel=1 and pc_target=VECTOR_ADDR for exactly one cycle, then go to HANDLER.
REQ-027 HANDLER: the block SHALL hold in_handler=1; eret=1 SHALL move it to RETURN.
REQ-028 RETURN: the block SHALL assert pc_sel=1 and pc_target=epc for one cycle, clear cause to 00, then go to IDLE. epc SHALL keep its value.
REQ-029 Events during FLUSH, VECTOR or RETURN SHALL be ignored, because those instructions are being squashed.
REQ-030 An event in HANDLER SHALL go to FATAL and SHALL NOT overwrite epc.
REQ-031 If an event and eret arrive in the same HANDLER cycle, the event SHALL win and the block SHALL go to FATAL.
REQ-032 FATAL: fatal=1, stall=1 and flush=1 SHALL hold until reset; the state SHALL be exited only by reset.
REQ-033 eret outside HANDLER SHALL be ignored.
REQ-034 Outputs SHALL be registered or decoded from state only, with no combinational path from inputs to outputs.
REQ-035 When pc_sel=0, pc_target SHALL be 16'h0000.

Reset
REQ-036 On rst the block SHALL enter IDLE, with flush=0, stall=0, pc_sel=0, pc_target=0, epc=0, cause=00, in_handler=0, fatal=0, exc_count=0, and the flush counter at 0.
REQ-037 Reset asserted in any state, including mid-FLUSH or FATAL, SHALL take effect immediately (asynchronously) and override every transition.

Structure
REQ-038 A shared package SHALL hold the state encoding, the cause codes (CAUSE_NONE, CAUSE_OVF, CAUSE_ILL) and the legal-opcode list.
REQ-039 A combinational sub-module exc_detect SHALL produce event and code from instruct, instr_valid and overflow; all sequencing SHALL stay in exc_sequencer.

Verification
REQ-040 Overflow: pc_in=16'h0123, opcode 4, overflow=1 -> epc=0123, cause=01, flush high for 2 cycles, then pc_sel=1 with pc_target=0FF0 for 1 cycle, then in_handler=1.
REQ-041 Illegal opcode: opcode 3, no overflow -> cause=10, exc_count=1; an eret pulse in HANDLER -> pc_target=0123 for 1 cycle, then IDLE with cause=00.
REQ-042 Both events in one cycle (opcode 3 with overflow=1) -> cause=01.
REQ-043 Nested event in HANDLER, issued together with eret -> fatal=1, epc unchanged; fatal stays 1 for 20 or more cycles and clears only on rst.
REQ-044 300 exceptions, each followed by eret -> exc_count saturates at 255; an eret pulse in IDLE -> no pc_sel.
REQ-045 rst asserted in the second FLUSH cycle -> all outputs reach their REQ-036 values before the next clock edge.

Source files
------------

// File: rtl/exc_sequencer_pkg.sv
// Shared definitions for the exception sequencer: FSM encoding, cause codes
// and the legal-opcode set.
package exc_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FLUSH   = 3'd1,
      VECTOR  = 3'd2,
      HANDLER = 3'd3,
      RETURN  = 3'd4,
      FATAL   = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE = 2'b00,
      CAUSE_OVF  = 2'b01,
      CAUSE_ILL  = 2'b10
   } cause_t;

   // Bit n set means opcode n is legal: {0,4,5,6,8,B,C,F}
   localparam logic [15:0] LEGAL_OPS = 16'h9971;

   function automatic logic is_legal(input logic [3:0] op);
      return LEGAL_OPS[op];
   endfunction

endpackage

// File: rtl/exc_sequencer_if.sv
// Decode-stage inputs and pipeline-control outputs of the exception sequencer.
interface exc_sequencer_if;
   logic [15:0] instruct;
   logic        instr_valid;
   logic        overflow;
   logic [15:0] pc_in;
   logic        eret;
   logic        flush;
   logic        stall;
   logic        pc_sel;
   logic [15:0] pc_target;
   logic [15:0] epc;
   logic [1:0]  cause;
   logic        in_handler;
   logic        fatal;
   logic [7:0]  exc_count;

   modport slave (
      input  instruct, instr_valid, overflow, pc_in, eret,
      output flush, stall, pc_sel, pc_target, epc, cause, in_handler, fatal, exc_count
   );

   modport master (
      output instruct, instr_valid, overflow, pc_in, eret,
      input  flush, stall, pc_sel, pc_target, epc, cause, in_handler, fatal, exc_count
   );
endinterface

// File: rtl/exc_sequencer_detect.sv
// Combinational exception detector; overflow outranks an illegal opcode.
module exc_detect
   import exc_sequencer_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic       instr_valid,
   input  logic       overflow,
   output logic       evt,
   output cause_t     code
);

   always_comb begin
      evt  = 1'b0;
      code = CAUSE_NONE;
      if (instr_valid && overflow) begin
         evt  = 1'b1;
         code = CAUSE_OVF;
      end else if (instr_valid && !is_legal(opcode)) begin
         evt  = 1'b1;
         code = CAUSE_ILL;
      end
   end

endmodule

// File: rtl/exc_sequencer.sv
// Exception sequencer: flushes the pipe, vectors to the handler, returns on
// eret and locks up on a nested exception.
module exc_sequencer
   import exc_sequencer_pkg::*;
#(
   parameter logic [15:0] VECTOR_ADDR  = 16'h0FF0,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input logic           clk,
   input logic           rst,
   exc_sequencer_if.slave bus
);

   localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

   state_t      state, next_state;
   logic [3:0]  flush_cnt;
   logic [15:0] epc_q;
   cause_t      cause_q;
   logic [7:0]  exc_cnt_q;
   logic        evt;
   cause_t      code;

   logic        flush, stall, pc_sel, in_handler, fatal;
   logic [15:0] pc_target;

   exc_detect u_detect (
      .opcode      (bus.instruct[15:12]),
      .instr_valid (bus.instr_valid),
      .overflow    (bus.overflow),
      .evt         (evt),
      .code        (code)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Outputs decode from state (and the epc register) only.
   always_comb begin
      next_state = state;
      flush      = 1'b0;
      stall      = 1'b0;
      pc_sel     = 1'b0;
      pc_target  = 16'h0000;
      in_handler = 1'b0;
      fatal      = 1'b0;
      case (state)
         IDLE:    if (evt) next_state = FLUSH;
         FLUSH: begin
            flush = 1'b1;
            stall = 1'b1;
            if (flush_cnt == 4'd0) next_state = VECTOR;
         end
         VECTOR: begin
            pc_sel     = 1'b1;
            pc_target  = VECTOR_ADDR;
            next_state = HANDLER;
         end
         HANDLER: begin
            in_handler = 1'b1;
            if (evt)          next_state = FATAL;
            else if (bus.eret) next_state = RETURN;
         end
         RETURN: begin
            pc_sel     = 1'b1;
            pc_target  = epc_q;
            next_state = IDLE;
         end
         FATAL: begin
            fatal = 1'b1;
            stall = 1'b1;
            flush = 1'b1;
         end
         default: next_state = IDLE;
      endcase
   end

   // Only an event taken from IDLE updates epc/cause/count; nested ones do not.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         epc_q     <= 16'h0000;
         cause_q   <= CAUSE_NONE;
         exc_cnt_q <= 8'h00;
         flush_cnt <= 4'd0;
      end else begin
         if (state == IDLE && evt) begin
            epc_q     <= bus.pc_in;
            cause_q   <= code;
            flush_cnt <= FLUSH_LAST;
            if (exc_cnt_q != 8'hFF) exc_cnt_q <= exc_cnt_q + 8'd1;
         end
         if (state == FLUSH && flush_cnt != 4'd0) flush_cnt <= flush_cnt - 4'd1;
         if (state == RETURN) cause_q <= CAUSE_NONE;
      end
   end

   assign bus.flush      = flush;
   assign bus.stall      = stall;
   assign bus.pc_sel     = pc_sel;
   assign bus.pc_target  = pc_target;
   assign bus.epc        = epc_q;
   assign bus.cause      = cause_q;
   assign bus.in_handler = in_handler;
   assign bus.fatal      = fatal;
   assign bus.exc_count  = exc_cnt_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed bench for exc_sequencer with hand-computed expectations.
module tb_exc_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   exc_sequencer_if bus ();

   exc_sequencer #(.VECTOR_ADDR(16'h0FF0), .FLUSH_CYCLES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.instruct    = 16'h0000;
      bus.instr_valid = 1'b0;
      bus.overflow    = 1'b0;
      bus.pc_in       = 16'h0000;
      bus.eret        = 1'b0;
   endtask

   task automatic raise(input logic [15:0] ins, input logic ovf, input logic [15:0] pc);
      bus.instruct    = ins;
      bus.instr_valid = 1'b1;
      bus.overflow    = ovf;
      bus.pc_in       = pc;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #3;
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      idle_in();
      #12;
      // reset values
      chk("rst_flush", 32'(bus.flush), 32'd0);
      chk("rst_stall", 32'(bus.stall), 32'd0);
      chk("rst_pcsel", 32'(bus.pc_sel), 32'd0);
      chk("rst_tgt", 32'(bus.pc_target), 32'h0);
      chk("rst_epc", 32'(bus.epc), 32'h0);
      chk("rst_cause", 32'(bus.cause), 32'd0);
      chk("rst_cnt", 32'(bus.exc_count), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // overflow on opcode 4
      raise(16'h4000, 1'b1, 16'h0123);
      tick();
      chk("ovf_epc", 32'(bus.epc), 32'h0123);
      chk("ovf_cause", 32'(bus.cause), 32'd1);
      chk("ovf_flush1", 32'(bus.flush), 32'd1);
      chk("ovf_stall1", 32'(bus.stall), 32'd1);
      chk("ovf_cnt", 32'(bus.exc_count), 32'd1);
      raise(16'h3000, 1'b0, 16'h0999);   // squashed, must be ignored
      tick();
      chk("ovf_flush2", 32'(bus.flush), 32'd1);
      chk("ovf_pcsel_f2", 32'(bus.pc_sel), 32'd0);
      tick();
      chk("vec_flush", 32'(bus.flush), 32'd0);
      chk("vec_pcsel", 32'(bus.pc_sel), 32'd1);
      chk("vec_tgt", 32'(bus.pc_target), 32'h0FF0);
      chk("ign_epc", 32'(bus.epc), 32'h0123);
      chk("ign_cause", 32'(bus.cause), 32'd1);
      idle_in();
      tick();
      chk("hdl_in", 32'(bus.in_handler), 32'd1);
      chk("hdl_pcsel", 32'(bus.pc_sel), 32'd0);
      chk("hdl_tgt", 32'(bus.pc_target), 32'h0);
      chk("ign_cnt", 32'(bus.exc_count), 32'd1);

      // illegal opcode 3, then return
      do_reset();
      raise(16'h3000, 1'b0, 16'h0123);
      tick();
      chk("ill_cause", 32'(bus.cause), 32'd2);
      chk("ill_cnt", 32'(bus.exc_count), 32'd1);
      idle_in();
      tick(); tick(); tick();
      chk("ill_hdl", 32'(bus.in_handler), 32'd1);
      bus.eret = 1'b1;
      tick();
      bus.eret = 1'b0;
      chk("ret_pcsel", 32'(bus.pc_sel), 32'd1);
      chk("ret_tgt", 32'(bus.pc_target), 32'h0123);
      tick();
      chk("ret_pcsel0", 32'(bus.pc_sel), 32'd0);
      chk("ret_cause", 32'(bus.cause), 32'd0);
      chk("ret_epc", 32'(bus.epc), 32'h0123);
      chk("ret_hdl", 32'(bus.in_handler), 32'd0);

      // both events at once, then nested event with eret
      raise(16'h3000, 1'b1, 16'h0200);
      tick();
      chk("both_cause", 32'(bus.cause), 32'd1);
      chk("both_cnt", 32'(bus.exc_count), 32'd2);
      idle_in();
      tick(); tick(); tick();
      raise(16'h7000, 1'b0, 16'h0456);
      bus.eret = 1'b1;
      tick();
      idle_in();
      chk("nest_fatal", 32'(bus.fatal), 32'd1);
      chk("nest_epc", 32'(bus.epc), 32'h0200);
      chk("nest_hdl", 32'(bus.in_handler), 32'd0);
      for (int i = 0; i < 20; i++) tick();
      bus.eret = 1'b1;
      tick();
      bus.eret = 1'b0;
      chk("fatal_hold", 32'(bus.fatal), 32'd1);
      chk("fatal_stall", 32'(bus.stall), 32'd1);
      chk("fatal_flush", 32'(bus.flush), 32'd1);
      rst = 1'b1;
      #1;
      chk("fatal_rst", 32'(bus.fatal), 32'd0);
      chk("fatal_rst_stall", 32'(bus.stall), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // 300 exceptions saturate the counter
      for (int i = 0; i < 300; i++) begin
         raise(16'h1000, 1'b0, 16'(i));
         tick();
         idle_in();
         tick(); tick(); tick();
         bus.eret = 1'b1;
         tick();
         bus.eret = 1'b0;
         tick();
      end
      chk("sat_cnt", 32'(bus.exc_count), 32'd255);
      chk("sat_epc", 32'(bus.epc), 32'd299);
      bus.eret = 1'b1;
      tick();
      bus.eret = 1'b0;
      chk("idle_eret_pcsel", 32'(bus.pc_sel), 32'd0);
      chk("idle_eret_hdl", 32'(bus.in_handler), 32'd0);

      // reset during second flush cycle
      raise(16'h4000, 1'b1, 16'h0ABC);
      tick();
      idle_in();
      tick();
      chk("mid_flush", 32'(bus.flush), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_flush", 32'(bus.flush), 32'd0);
      chk("mid_rst_stall", 32'(bus.stall), 32'd0);
      chk("mid_rst_pcsel", 32'(bus.pc_sel), 32'd0);
      chk("mid_rst_tgt", 32'(bus.pc_target), 32'h0);
      chk("mid_rst_epc", 32'(bus.epc), 32'h0);
      chk("mid_rst_cause", 32'(bus.cause), 32'd0);
      chk("mid_rst_cnt", 32'(bus.exc_count), 32'd0);
      chk("mid_rst_fatal", 32'(bus.fatal), 32'd0);
      chk("mid_rst_hdl", 32'(bus.in_handler), 32'd0);
      rst = 1'b0;
      tick(); tick(); tick();
      chk("post_rst_pcsel", 32'(bus.pc_sel), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
